// File: rtl/drive_cmd_arbiter.sv
// Merges drive commands from NUM_SRC sources into one valid/ready stream; a command is sent only when it changes.
// Optional CMD_REFRESH_EN macro: periodically re-send the last command while idle.

module drive_cmd_src_slot #(
    parameter int CMD_W       = 4,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_i,
    input  logic             en_i,
    input  logic [CMD_W-1:0] cmd_i,
    output logic             live_o,
    output logic [CMD_W-1:0] cmd_o
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic             live_q, live_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;

    // Capture beats expiry; a disabled source drops out on the next edge.
    always_comb begin
        live_d  = live_q;
        timer_d = timer_q;
        cmd_d   = cmd_q;
        if (!en_i) begin
            live_d  = 1'b0;
            timer_d = '0;
        end else if (cap_i) begin
            live_d  = 1'b1;
            timer_d = TW'(TIMEOUT_CYC - 1);
            cmd_d   = cmd_i;
        end else if (live_q) begin
            if (timer_q == '0) live_d = 1'b0;
            else               timer_d = timer_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live_q  <= 1'b0;
            timer_q <= '0;
            cmd_q   <= '0;
        end else begin
            live_q  <= live_d;
            timer_q <= timer_d;
            cmd_q   <= cmd_d;
        end
    end

    assign live_o = live_q;
    assign cmd_o  = cmd_q;
endmodule

module drive_cmd_arbiter #(
    parameter int NUM_SRC     = 3,
    parameter int CMD_W       = 4,
    parameter int TIMEOUT_CYC = 25000000,
    parameter int MODE        = 0,
    parameter int STOP_CMD    = 0,
    parameter int REFRESH_CYC = 50000000
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_SRC-1:0]                            src_valid,
    input  logic [NUM_SRC*CMD_W-1:0]                      src_cmd,
    input  logic [NUM_SRC-1:0]                            src_enable,
    output logic [CMD_W-1:0]                              out_cmd,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] active_src,
    output logic                                          active_valid
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CMD_W-1:0] STOP = CMD_W'(STOP_CMD);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [NUM_SRC-1:0]            cap, live;
    logic [NUM_SRC-1:0][CMD_W-1:0] slot_cmd;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        assign cap[g] = src_valid[g] & src_enable[g];
        drive_cmd_src_slot #(.CMD_W(CMD_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .cap_i  (cap[g]),
            .en_i   (src_enable[g]),
            .cmd_i  (src_cmd[g*CMD_W +: CMD_W]),
            .live_o (live[g]),
            .cmd_o  (slot_cmd[g])
        );
    end

    logic [SRC_W-1:0] lo_live, lo_cap, sel_idx, last_src_q, last_src_d, act_src_q, act_src_d;
    logic             any_cap, any_live;
    logic [CMD_W-1:0] sel_cmd;

    always_comb begin
        lo_live = '0;
        lo_cap  = '0;
        any_cap = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (live[i]) lo_live = SRC_W'(i);
            if (cap[i]) begin
                lo_cap  = SRC_W'(i);
                any_cap = 1'b1;
            end
        end
    end

    assign any_live   = |live;
    assign last_src_d = any_cap ? lo_cap : last_src_q;
    assign sel_idx    = (MODE == 1 && live[last_src_q]) ? last_src_q : lo_live;
    assign sel_cmd    = any_live ? slot_cmd[sel_idx] : STOP;
    assign act_src_d  = any_live ? sel_idx : act_src_q;

    logic [0:0]       state_q, state_d;
    logic [CMD_W-1:0] out_cmd_q, out_cmd_d, last_sent_q, last_sent_d;
    logic             out_valid_q, out_valid_d;

`ifdef CMD_REFRESH_EN
    localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    logic [RW-1:0] refresh_q, refresh_d;
`else
    logic unused_refresh;
    assign unused_refresh = (REFRESH_CYC > 0);
`endif

    always_comb begin
        state_d     = state_q;
        out_cmd_d   = out_cmd_q;
        out_valid_d = out_valid_q;
        last_sent_d = last_sent_q;
`ifdef CMD_REFRESH_EN
        refresh_d   = refresh_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_cmd != last_sent_q) begin
                    out_cmd_d   = sel_cmd;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
`ifdef CMD_REFRESH_EN
                end else if (refresh_q == RW'(REFRESH_CYC - 1)) begin
                    out_cmd_d   = last_sent_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end else begin
                    refresh_d   = refresh_q + 1'b1;
`endif
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    last_sent_d = out_cmd_q;
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
`ifdef CMD_REFRESH_EN
                    refresh_d   = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_cmd_q   <= STOP;
            out_valid_q <= 1'b0;
            last_sent_q <= STOP;
            last_src_q  <= '0;
            act_src_q   <= '0;
`ifdef CMD_REFRESH_EN
            refresh_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_cmd_q   <= out_cmd_d;
            out_valid_q <= out_valid_d;
            last_sent_q <= last_sent_d;
            last_src_q  <= last_src_d;
            act_src_q   <= act_src_d;
`ifdef CMD_REFRESH_EN
            refresh_q   <= refresh_d;
`endif
        end
    end

    assign out_cmd      = out_cmd_q;
    assign out_valid    = out_valid_q;
    assign active_src   = act_src_d;
    assign active_valid = any_live;
endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Scoreboard bench: A = fixed priority, B = latest-wins, C = refresh behaviour (CMD_REFRESH_EN aware).
module tb_drive_cmd_arbiter;
    localparam int REF_C = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  sv_a = '0, en_a = '1, sv_b = '0, en_b = '1, sv_c = '0, en_c = '1;
    logic [11:0] sc_a = '0, sc_b = '0, sc_c = '0;
    logic        rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
    logic [3:0]  oc_a, oc_b, oc_c;
    logic        ov_a, ov_b, ov_c, av_a, av_b, av_c;
    logic [1:0]  as_a, as_b, as_c;

    drive_cmd_arbiter #(.NUM_SRC(3), .CMD_W(4), .TIMEOUT_CYC(8), .MODE(0), .STOP_CMD(0), .REFRESH_CYC(100000)) u_a (
        .clk(clk), .rst_n(rst_n), .src_valid(sv_a), .src_cmd(sc_a), .src_enable(en_a),
        .out_cmd(oc_a), .out_valid(ov_a), .out_ready(rdy_a), .active_src(as_a), .active_valid(av_a));
    drive_cmd_arbiter #(.NUM_SRC(3), .CMD_W(4), .TIMEOUT_CYC(8), .MODE(1), .STOP_CMD(0), .REFRESH_CYC(100000)) u_b (
        .clk(clk), .rst_n(rst_n), .src_valid(sv_b), .src_cmd(sc_b), .src_enable(en_b),
        .out_cmd(oc_b), .out_valid(ov_b), .out_ready(rdy_b), .active_src(as_b), .active_valid(av_b));
    drive_cmd_arbiter #(.NUM_SRC(3), .CMD_W(4), .TIMEOUT_CYC(8), .MODE(0), .STOP_CMD(0), .REFRESH_CYC(REF_C)) u_c (
        .clk(clk), .rst_n(rst_n), .src_valid(sv_c), .src_cmd(sc_c), .src_enable(en_c),
        .out_cmd(oc_c), .out_valid(ov_c), .out_ready(rdy_c), .active_src(as_c), .active_valid(av_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected transfer sequences; a handshake is seen at the negedge before the accepting edge.
    logic [3:0] qa[$], qb[$];
    int         ct[$];
    logic       c_win = 1'b0, c_done = 1'b0;

    always @(negedge clk) begin
        if (rst_n && ov_a && rdy_a) begin
            if (qa.size() == 0) chk("a_unexpected_send", qa.size(), 1);
            else chk("a_sb_cmd", oc_a, qa.pop_front());
        end
        if (rst_n && ov_b && rdy_b) begin
            if (qb.size() == 0) chk("b_unexpected_send", qb.size(), 1);
            else chk("b_sb_cmd", oc_b, qb.pop_front());
        end
        if (c_win && ov_c && rdy_c) begin
            chk("c_cmd", oc_c, 5);
            ct.push_back(cyc);
        end
    end

    // Source 0 of C is kept live with cmd 5 for a fixed window.
    initial begin
        wait (rst_n == 1'b1);
        sc_c = 12'h005;
        c_win = 1'b1;
        for (int k = 0; k < 120; k++) begin
            sv_c = {2'b00, (k % 4 == 0)};
            step();
        end
        sv_c = '0;
        c_win = 1'b0;
        c_done = 1'b1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // Reset and quiet period
        #1;
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("rst_out_valid", ov_a, 0);
            chk("rst_out_cmd", oc_a, 0);
            chk("rst_active_valid", av_a, 0);
        end

        // Single pulse on src1: send after t+1, expiry at t+8, STOP after t+9
        qa.push_back(4'd5);
        qa.push_back(4'd0);
        sv_a = 3'b010;
        sc_a = 12'h050;
        step();
        sv_a = '0;
        chk("p_active_src", as_a, 1);
        chk("p_active_valid", av_a, 1);
        chk("p_no_valid_yet", ov_a, 0);
        step();
        chk("p_out_valid", ov_a, 1);
        chk("p_out_cmd", oc_a, 5);
        step();
        chk("p_valid_one_cycle", ov_a, 0);
        repeat (5) step();
        chk("p_live_t7", av_a, 1);
        step();
        chk("p_expired_t8", av_a, 0);
        chk("p_active_src_hold", as_a, 1);
        chk("p_no_stop_yet", ov_a, 0);
        step();
        chk("p_stop_valid", ov_a, 1);
        chk("p_stop_cmd", oc_a, 0);
        repeat (4) step();

        // Fixed priority: src2=3 refreshed, src0=7 pulse overrides then expires
        qa.push_back(4'd3);
        qa.push_back(4'd7);
        qa.push_back(4'd3);
        qa.push_back(4'd0);
        sc_a = 12'h307;
        for (int k = 0; k < 55; k++) begin
            sv_a = {(k % 4 == 0 && k < 40), 1'b0, (k == 12)};
            step();
            if (k == 12) chk("fp_active_src0", as_a, 0);
            if (k == 24) begin
                chk("fp_active_src2", as_a, 2);
                chk("fp_active_valid", av_a, 1);
            end
        end
        sv_a = '0;

        // Backpressure: 5 held while selection moves 6 -> 9; 6 is dropped
        qa.push_back(4'd5);
        qa.push_back(4'd9);
        qa.push_back(4'd0);
        rdy_a = 1'b0;
        sv_a = 3'b010;
        sc_a = 12'h050;
        step();
        sv_a = '0;
        step();
        chk("bp_valid", ov_a, 1);
        chk("bp_cmd5", oc_a, 5);
        sv_a = 3'b010;
        sc_a = 12'h060;
        step();
        sc_a = 12'h090;
        step();
        sv_a = '0;
        step();
        step();
        chk("bp_held_valid", ov_a, 1);
        chk("bp_held_cmd", oc_a, 5);
        rdy_a = 1'b1;
        step();
        step();
        chk("bp_next_valid", ov_a, 1);
        chk("bp_next_cmd", oc_a, 9);
        repeat (15) step();

        // Latest-wins on B
        qb.push_back(4'd7);
        qb.push_back(4'd3);
        qb.push_back(4'd7);
        qb.push_back(4'd1);
        qb.push_back(4'd0);
        for (int k = 0; k < 25; k++) begin
            sv_b = '0;
            case (k)
                0: begin sv_b = 3'b001; sc_b = 12'h007; end
                2: begin sv_b = 3'b100; sc_b = 12'h307; end
                4: en_b = 3'b011;
                6: begin sv_b = 3'b011; sc_b = 12'h391; end
                default: ;
            endcase
            step();
            if (k == 2) chk("lw_active_src2", as_b, 2);
            if (k == 4) chk("lw_fallback_src0", as_b, 0);
            if (k == 6) chk("lw_same_edge_src0", as_b, 0);
        end
        sv_b = '0;
        en_b = 3'b111;

        for (int i = 0; i < 500 && !c_done; i++) step();
        chk("c_window_done", c_done, 1);
`ifdef CMD_REFRESH_EN
        chk("c_refresh_count", ct.size() >= 4, 1);
        // REFRESH_CYC idle cycles plus the SEND cycle between accepted transfers
        for (int i = 1; i < ct.size(); i++) chk("c_refresh_period", ct[i] - ct[i-1], REF_C + 1);
`else
        chk("c_single_send", ct.size(), 1);
`endif
        chk("a_sb_drain", qa.size(), 0);
        chk("b_sb_drain", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/drive_cmd_arbiter.md
Name: drive_cmd_arbiter

Overview:
Parametrised arbiter that merges drive commands from several control sources into one stream for the UART JSON sender. Typical sources are the IR remote, mic pitch mapping and camera direction/classifier. Generalises the current hard-wired source-to-drive_state path:
- N sources, with per-source expiry and enable masking.
- Selectable fixed-priority or latest-wins mode.
- valid/ready output handshake; a command is sent only when it changes.

Parameters:
NUM_SRC, 3, number of command sources (>=1)
CMD_W, 4, command width in bits
TIMEOUT_CYC, 25000000, cycles a captured command stays live after its last src_valid (>=1)
MODE, 0, 0 = fixed priority (lowest index wins), 1 = latest-wins
STOP_CMD, 0, command emitted when no source is live
REFRESH_CYC, 50000000, re-send period; used only with CMD_REFRESH_EN

Ports:
clk  in  1  system clock (clk_50 domain)
rst_n  in  1  synchronous active-low reset
src_valid  in  NUM_SRC  per-source command strobe
src_cmd  in  NUM_SRC*CMD_W  packed commands; source i at bits [i*CMD_W +: CMD_W]
src_enable  in  NUM_SRC  per-source mask; 0 ignores and expires that source
out_cmd  out  CMD_W  command to UART sender
out_valid  out  1  out_cmd valid
out_ready  in  1  UART sender accepts
active_src  out  SRC_W  index of selected source; SRC_W = max(1, $clog2(NUM_SRC))
active_valid  out  1  at least one source live

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All live flags, timers and captured commands clear.
  - last_sent=STOP_CMD, out_cmd=STOP_CMD, out_valid=0, active_src=0, active_valid=0, FSM=IDLE.
  - Reset during SEND drops out_valid at that edge and abandons the command.
- Per-source capture (edge with src_valid[i] & src_enable[i]):
  - Latch cmd[i], set live[i]=1, load timer[i]=TIMEOUT_CYC-1.
  - A repeated identical cmd only reloads the timer.
- Per-source expiry:
  - While live and not capturing, timer decrements each cycle.
  - At timer=0 with no capture, live clears on the next edge, so a single pulse keeps the source live for exactly TIMEOUT_CYC cycles.
  - Capture and expiry on the same edge: capture wins.
  - src_enable[i]=0 clears live[i] on the next edge.
- Selection (combinational from registered state):
  - MODE 0: lowest-index live source.
  - MODE 1: last_src register is loaded with the lowest index capturing on that edge. If last_src is live it wins; otherwise fall back to lowest-index live.
  - No source live: selected cmd = STOP_CMD, active_valid=0, active_src holds its last value.
- Output FSM:
  - IDLE: if sel_cmd != last_sent, load out_cmd=sel_cmd, out_valid=1, go to SEND.
  - SEND: out_cmd frozen. On out_valid & out_ready: last_sent=out_cmd, out_valid=0, back to IDLE.
  - Selection changes during SEND are not sent mid-transfer. After the handshake IDLE compares again, so only the newest selection is sent; intermediate values are dropped.
  - Minimum one IDLE cycle between transfers.
- Latency:
  - src_valid sampled at edge t → selection visible after t.
  - out_valid high after edge t+1 when the FSM is idle and out_ready=1.
  - Expiry to STOP_CMD uses the same 1-cycle FSM latency.

Optional Feature:
CMD_REFRESH_EN:
- Defined: a refresh counter runs in IDLE and resets on every completed handshake. When it reaches REFRESH_CYC-1 with no pending change, the FSM re-sends last_sent. This covers lost UART frames.
- Undefined: no counter; sends occur only on change.

Test Plan:
- Reset: rst_n low 3 cycles, then no stimulus for 20 cycles → out_valid=0 throughout, out_cmd=0, active_valid=0.
- Params NUM_SRC=3, CMD_W=4, TIMEOUT_CYC=8, MODE=0, out_ready=1. Single src_valid[1] pulse with cmd 5 at edge t:
  - out_valid=1 with out_cmd=5 for one cycle after edge t+1; active_src=1.
  - live expires after t+8; then out_cmd=0 is sent one cycle later.
- Fixed priority: src2 cmd=3 refreshed every 4 cycles; then src0 cmd=7 pulses → sends 7. After src0 expires → sends 3. No duplicate sends while unchanged.
- Latest-wins (MODE=1):
  - src0 cmd=7 live, then src2 cmd=3 → sends 3, active_src=2.
  - src0 and src1 capture on the same edge → src0 wins.
  - src_enable[2]=0 → falls back to src0, sends 7.
- Backpressure: out_ready=0 while selection goes 5→6→9 → out_cmd held at 5. Ready asserted → 5 accepted, then 9 sent; 6 never appears.
- CMD_REFRESH_EN, REFRESH_CYC=20, src0 cmd=5 held live → 5 re-sent every 20 IDLE cycles. Without the macro → exactly one send.
